key_event_gen: RTL and testbench

Debounced key-event source for the board pushbuttons. It turns raw active-low key inputs into clean single-cycle press and release pulses, a held level, and optional auto-repeat pulses. It is the producing end of the keypress-event interface that the lab counters and registers consume. It sits between the key pins and any logic that currently derives its own press edges.

---
 rtl/key_pkg.sv | 26 ++
 rtl/key_channel.sv | 113 +++++++++++
 rtl/key_event_gen.sv | 39 +++
 tb/tb_key_event_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the pushbutton key-event source.
package key_pkg;

    // Per-channel debounce/hold state.
    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_e;

    // Default timing for a 100 MHz clock.
    localparam int unsigned DEBOUNCE_CYCLES_100M = 1000000;  // 10 ms
    localparam int unsigned REPEAT_DELAY_100M    = 50000000; // 0.5 s
    localparam int unsigned REPEAT_PERIOD_100M   = 10000000; // 0.1 s

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchronizer, debounce FSM, auto-repeat timer, registered outputs.
module key_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100M,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_100M,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_100M
) (
    input  logic clk100_i,
    input  logic rstn_i,
    input  logic key_i,
    input  logic repeat_en_i,
    output logic press_o,
    output logic release_o,
    output logic repeat_o,
    output logic held_o,
    output logic event_o
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RW = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RCNT_DELAY = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RCNT_PER   = RW'(REPEAT_PERIOD - 1);

    logic          s1, s2;
    key_state_e    state;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;

    // Synchronize the raw pin; inverted so that s2 = 1 means pressed.
    always_ff @(posedge clk100_i) begin
        if (!rstn_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= ~key_i;
            s2 <= s1;
        end
    end

    // Debounce FSM with repeat timer; every output is a register.
    always_ff @(posedge clk100_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            dcnt      <= '0;
            rcnt      <= '0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            repeat_o  <= 1'b0;
            held_o    <= 1'b0;
            event_o   <= 1'b0;
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            repeat_o  <= 1'b0;
            event_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    held_o <= 1'b0;
                    if (s2) begin
                        dcnt  <= '0;
                        state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (dcnt == DCNT_LAST) begin
                        press_o <= 1'b1;
                        event_o <= 1'b1;
                        held_o  <= 1'b1;
                        rcnt    <= RCNT_DELAY;
                        state   <= HELD;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                HELD: begin
                    held_o <= 1'b1;
                    if (!s2) begin
                        dcnt  <= '0;
                        state <= RELEASE_WAIT;
                    end else if (repeat_en_i) begin
                        if (rcnt == '0) begin
                            repeat_o <= 1'b1;
                            event_o  <= 1'b1;
                            rcnt     <= RCNT_PER;
                        end else begin
                            rcnt <= rcnt - RW'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    // Repeats are suppressed here; a bounce back restarts the period.
                    if (s2) begin
                        rcnt  <= RCNT_PER;
                        state <= HELD;
                    end else if (dcnt == DCNT_LAST) begin
                        release_o <= 1'b1;
                        held_o    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// Debounced key-event source: NKEYS independent key_channel instances.
module key_event_gen
    import key_pkg::*;
#(
    parameter int unsigned NKEYS           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100M,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_100M,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_100M
) (
    input  logic             clk100_i,
    input  logic             rstn_i,
    input  logic [NKEYS-1:0] key_i,
    input  logic [NKEYS-1:0] repeat_en_i,
    output logic [NKEYS-1:0] press_o,
    output logic [NKEYS-1:0] release_o,
    output logic [NKEYS-1:0] repeat_o,
    output logic [NKEYS-1:0] held_o,
    output logic [NKEYS-1:0] event_o
);

    for (genvar i = 0; i < NKEYS; i++) begin : g_chan
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk100_i   (clk100_i),
            .rstn_i     (rstn_i),
            .key_i      (key_i[i]),
            .repeat_en_i(repeat_en_i[i]),
            .press_o    (press_o[i]),
            .release_o  (release_o[i]),
            .repeat_o   (repeat_o[i]),
            .held_o     (held_o[i]),
            .event_o    (event_o[i])
        );
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen with a run-length reference model.
module tb_key_event_gen;

    localparam int unsigned D  = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;

    logic       clk100 = 1'b0;
    logic       rstn;
    logic [1:0] key;
    logic [1:0] ren;
    logic [1:0] press, rel, rep, held, evt;

    int checks   = 0;
    int failures = 0;

    // Reference model: a level flips after D+1 consecutive opposite synchronized
    // samples; the repeat timer counts enabled cycles spent stably held.
    logic [1:0] m_p1, m_p2;
    bit         m_level [2];
    int         m_run   [2];
    int         m_rem   [2];
    logic [1:0] e_press, e_rel, e_rep, e_held, e_evt;

    key_event_gen #(
        .NKEYS          (2),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk100_i   (clk100),
        .rstn_i     (rstn),
        .key_i      (key),
        .repeat_en_i(ren),
        .press_o    (press),
        .release_o  (rel),
        .repeat_o   (rep),
        .held_o     (held),
        .event_o    (evt)
    );

    always #5 clk100 = ~clk100;

    task automatic model_step(input logic [1:0] k, input logic [1:0] en, input logic rst_n);
        logic [1:0] s;
        e_press = '0; e_rel = '0; e_rep = '0; e_evt = '0;
        if (!rst_n) begin
            m_p1 = '0; m_p2 = '0;
            for (int i = 0; i < 2; i++) begin
                m_level[i] = 0; m_run[i] = 0; m_rem[i] = 0;
            end
            e_held = '0;
            return;
        end
        s    = m_p2;
        m_p2 = m_p1;
        m_p1 = ~k;
        for (int i = 0; i < 2; i++) begin
            if (!m_level[i]) begin
                if (s[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        e_press[i] = 1'b1; m_level[i] = 1; m_run[i] = 0; m_rem[i] = RD;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end else if (m_run[i] == 0 && s[i]) begin
                if (en[i]) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        e_rep[i] = 1'b1; m_rem[i] = RP;
                    end
                end
            end else if (!s[i]) begin
                m_run[i]++;
                if (m_run[i] == D + 1) begin
                    e_rel[i] = 1'b1; m_level[i] = 0; m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0; m_rem[i] = RP;
            end
            e_held[i] = m_level[i];
        end
        e_evt = e_press | e_rep;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: model consumes the inputs present at the edge, outputs sampled 1 ns later.
    task automatic tick();
        logic [1:0] k, en;
        logic       r;
        k = key; en = ren; r = rstn;
        @(posedge clk100);
        model_step(k, en, r);
        #1;
        chk("press_o",   32'(press), 32'(e_press));
        chk("release_o", 32'(rel),   32'(e_rel));
        chk("repeat_o",  32'(rep),   32'(e_rep));
        chk("held_o",    32'(held),  32'(e_held));
        chk("event_o",   32'(evt),   32'(e_evt));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Edges from the first sample of the new input until press/release matches mask.
    task automatic measure(input bit want_rel, input logic [1:0] mask, output int n);
        n = 0;
        tick();
        while (((want_rel ? rel : press) & mask) != mask && n < 30) begin
            n++;
            tick();
        end
    endtask

    int n, cnt_p, cnt_r, cnt_rep, cnt_evt;

    initial begin
        rstn = 1'b0; key = 2'b00; ren = 2'b00;
        model_step(key, ren, 1'b0);
        ticks(4);

        // Reset release with both keys already pressed.
        rstn = 1'b1;
        measure(1'b0, 2'b11, n);
        chk("reset_press_latency", 32'(n), 32'd6);
        key = 2'b11;
        measure(1'b1, 2'b11, n);
        chk("reset_release_latency", 32'(n), 32'd6);
        ticks(3);

        // Clean press of key 0, no repeat.
        key = 2'b10;
        measure(1'b0, 2'b01, n);
        chk("clean_press_latency", 32'(n), 32'd6);
        cnt_rep = 0;
        for (int i = 0; i < 14; i++) begin tick(); cnt_rep += int'(rep[0]); end
        chk("clean_no_repeat", 32'(cnt_rep), 32'd0);
        key = 2'b11;
        measure(1'b1, 2'b01, n);
        chk("clean_release_latency", 32'(n), 32'd6);
        ticks(3);

        // Bounce: 3 low, 1 high, then low.
        cnt_p = 0;
        key = 2'b10;
        for (int i = 0; i < 3; i++) begin tick(); cnt_p += int'(press[0]); end
        key = 2'b11;
        tick(); cnt_p += int'(press[0]);
        key = 2'b10;
        measure(1'b0, 2'b01, n);
        cnt_p += int'(press[0]);
        chk("bounce_press_latency", 32'(n), 32'd6);
        for (int i = 0; i < 8; i++) begin tick(); cnt_p += int'(press[0]); end
        chk("bounce_single_press", 32'(cnt_p), 32'd1);
        key = 2'b11;
        ticks(9);

        // Auto-repeat on key 1.
        ren = 2'b10;
        key = 2'b01;
        measure(1'b0, 2'b10, n);
        chk("repeat_press_latency", 32'(n), 32'd6);
        cnt_rep = 0; cnt_evt = 0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (rep[1]) begin
                cnt_rep++;
                chk("repeat_position", 32'((i - 10) % 3), 32'd0);
            end
            cnt_evt += int'(evt[1]);
        end
        chk("repeat_count", 32'(cnt_rep), 32'd5);
        chk("repeat_event_count", 32'(cnt_evt), 32'd5);
        // Disable mid-hold, then re-enable.
        ren = 2'b00; ticks(5);
        ren = 2'b10; ticks(6);
        key = 2'b11;
        ticks(9);

        // Release glitch on key 0 while held with repeat enabled.
        ren = 2'b01;
        key = 2'b10;
        ticks(10);
        key = 2'b11; ticks(2);
        key = 2'b10;
        cnt_p = 0; cnt_r = 0;
        for (int i = 0; i < 12; i++) begin
            tick(); cnt_p += int'(press[0]); cnt_r += int'(rel[0]);
        end
        chk("glitch_no_press", 32'(cnt_p), 32'd0);
        chk("glitch_no_release", 32'(cnt_r), 32'd0);
        chk("glitch_held", 32'(held[0]), 32'd1);
        key = 2'b11;
        ticks(9);

        // Independence: key 1 then key 0 two cycles later; reset while held.
        ren = 2'b00;
        key = 2'b01;
        measure(1'b0, 2'b10, n);
        chk("indep_key1_latency", 32'(n), 32'd6);
        ticks(2);
        key = 2'b00;
        ticks(10);
        rstn = 1'b0; ticks(2);
        chk("reset_clears_held", 32'(held), 32'd0);
        rstn = 1'b1;
        measure(1'b0, 2'b11, n);
        chk("re_debounce_after_reset", 32'(n), 32'd6);
        key = 2'b11;
        ticks(8);

        // Randomized phase against the model.
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 5) == 0) key[b] = ~key[b];
                if ($urandom_range(0, 19) == 0) ren[b] = ~ren[b];
            end
            rstn = ($urandom_range(0, 249) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
